// File: rtl/mat_mult_sched.sv
// Round-robin scheduler sharing one mat_mult datapath between two requesters.
// Optional RUN watchdog compiled in with `define MAT_SCHED_TIMEOUT_EN.
module mat_mult_sched #(
    parameter int N_ROWS         = 2,
    parameter int N_COLUMNS      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  int         req_mat1   [0:1][0:N_ROWS-1][0:N_COLUMNS-1],
    input  int         req_mat2   [0:1][0:N_ROWS-1][0:N_COLUMNS-1],
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic       rsp_error,
    output int         rsp_mat    [0:N_ROWS-1][0:N_COLUMNS-1],
    output logic       mm_reset,
    output logic       mm_enable,
    output int         mm_mat1    [0:N_ROWS-1][0:N_COLUMNS-1],
    output int         mm_mat2    [0:N_ROWS-1][0:N_COLUMNS-1],
    input  logic       mm_done,
    input  int         mm_mat_out [0:N_ROWS-1][0:N_COLUMNS-1]
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_RESP
    } state_t;

`ifdef MAT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT_CYCLES - 1);
`else
    // Without the watchdog only "past the first RUN cycle" matters.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? 1 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(1);
`endif

    state_t        r_state;
    logic          r_last;
    logic          r_id;
    logic [CW-1:0] r_run_cnt;
    int            r_mat1    [0:N_ROWS-1][0:N_COLUMNS-1];
    int            r_mat2    [0:N_ROWS-1][0:N_COLUMNS-1];
    int            r_rsp_mat [0:N_ROWS-1][0:N_COLUMNS-1];
`ifdef MAT_SCHED_TIMEOUT_EN
    logic          r_rsp_error;
`endif

    logic w_winner;
    logic w_accept;

    always_comb begin
        w_winner = (req_valid == 2'b11) ? ~r_last : req_valid[1];
        w_accept = (r_state == S_IDLE) && !reset && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (w_accept) req_ready = w_winner ? 2'b10 : 2'b01;
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_mat   = r_rsp_mat;
    assign mm_reset  = reset | (r_state == S_CLEAR);
    assign mm_enable = (r_state == S_RUN);
    assign mm_mat1   = r_mat1;
    assign mm_mat2   = r_mat2;
`ifdef MAT_SCHED_TIMEOUT_EN
    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_run_cnt <= '0;
            r_mat1    <= '{default: 0};
            r_mat2    <= '{default: 0};
            r_rsp_mat <= '{default: 0};
`ifdef MAT_SCHED_TIMEOUT_EN
            r_rsp_error <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mat1  <= req_mat1[w_winner];
                        r_mat2  <= req_mat2[w_winner];
                        r_id    <= w_winner;
                        r_last  <= w_winner;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_run_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    // The done flag on the first RUN cycle is left over from the last job.
                    if ((r_run_cnt != '0) && mm_done) begin
                        r_rsp_mat <= mm_mat_out;
`ifdef MAT_SCHED_TIMEOUT_EN
                        r_rsp_error <= 1'b0;
`endif
                        r_state   <= S_RESP;
                    end
`ifdef MAT_SCHED_TIMEOUT_EN
                    else if (r_run_cnt == CNT_TO) begin
                        r_rsp_mat   <= '{default: 0};
                        r_rsp_error <= 1'b1;
                        r_state     <= S_RESP;
                    end
`endif
                    if (r_run_cnt != CNT_MAX) r_run_cnt <= r_run_cnt + CW'(1);
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Directed self-checking bench for mat_mult_sched with a behavioural
// mat_mult stand-in whose done latency can be tuned or suppressed.
module tb_mat_mult_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    int         req_mat1   [0:1][0:1][0:1];
    int         req_mat2   [0:1][0:1][0:1];
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic       rsp_error;
    int         rsp_mat    [0:1][0:1];
    logic       mm_reset;
    logic       mm_enable;
    int         mm_mat1    [0:1][0:1];
    int         mm_mat2    [0:1][0:1];
    logic       mm_done;
    int         mm_mat_out [0:1][0:1];

    int n_assert = 0;
    int n_fail   = 0;
    int viol     = 0;
    int dp_cnt   = 0;
    int tb_lat   = 1;
    bit tb_force_low = 1'b0;
    int cyc;

    always #5 clk = ~clk;

    mat_mult_sched #(
        .N_ROWS(2),
        .N_COLUMNS(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mat1(req_mat1),
        .req_mat2(req_mat2),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_error(rsp_error),
        .rsp_mat(rsp_mat),
        .mm_reset(mm_reset),
        .mm_enable(mm_enable),
        .mm_mat1(mm_mat1),
        .mm_mat2(mm_mat2),
        .mm_done(mm_done),
        .mm_mat_out(mm_mat_out)
    );

    always @(posedge clk) begin
        if (mm_reset) dp_cnt <= 0;
        else if (mm_enable) dp_cnt <= dp_cnt + 1;
    end

    assign mm_done = !tb_force_low && (dp_cnt >= tb_lat);

    always_comb begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mm_mat_out[i][j] = mm_mat1[i][0] * mm_mat2[0][j]
                                 + mm_mat1[i][1] * mm_mat2[1][j];
    end

    always @(negedge clk) begin
        if (req_ready == 2'b11) viol <= viol + 1;
        if ((req_ready != 2'b00) && (mm_enable || mm_reset || rsp_valid))
            viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the CLEAR cycle; cyc counts from req_ready.
    task automatic wait_rsp(output int c);
        c = 1;
        while (!rsp_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic do_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_mat(input string tag, input int a, input int b,
                           input int c, input int d);
        chk({tag, "_00"}, rsp_mat[0][0], a);
        chk({tag, "_01"}, rsp_mat[0][1], b);
        chk({tag, "_10"}, rsp_mat[1][0], c);
        chk({tag, "_11"}, rsp_mat[1][1], d);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req_mat1[0] = '{'{1, 0}, '{0, 1}};
        req_mat2[0] = '{'{1, 2}, '{3, 4}};
        req_mat1[1] = '{'{-1, 2}, '{0, 3}};
        req_mat2[1] = '{'{4, 0}, '{1, -2}};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rsp_mat", rsp_mat[1][1], 0);
        chk("rst_mm_enable", mm_enable, 0);
        chk("rst_mm_reset", mm_reset, 1);
        chk("rst_mm_mat1", mm_mat1[0][0], 0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready_gated", req_ready, 0);
        reset = 1'b0;

        // Simultaneous requests from reset: 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            wait_rsp(cyc);
            chk("rr_latency", cyc, 4);
            chk("rr_id", rsp_id, k % 2);
            chk("rr_m00", rsp_mat[0][0], (k % 2 == 0) ? 1 : -2);
            do_rsp();
        end
        req_valid = 2'b00;
        #1;
        chk("idle_no_ready", req_ready, 0);
        @(negedge clk);

        // Identity multiply, operands changed after acceptance.
        req_valid = 2'b01;
        #1;
        chk("id_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        req_mat2[0][0][0] = 99;
        chk("clr_mm_reset", mm_reset, 1);
        chk("clr_mm_enable", mm_enable, 0);
        @(negedge clk);
        chk("run_mm_enable", mm_enable, 1);
        chk("run_mm_reset", mm_reset, 0);
        chk("run_mm_mat2", mm_mat2[1][1], 4);
        cyc = 2;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("id_latency", cyc, 4);
        chk_mat("id", 1, 2, 3, 4);
        chk("id_id", rsp_id, 0);
        chk("id_err", rsp_error, 0);
        do_rsp();
        chk("id_rsp_drop", rsp_valid, 0);
        req_mat2[0][0][0] = 1;

        // Signed operands from requester 1, with back-pressure.
        req_valid = 2'b10;
        #1;
        chk("sg_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b01;
        wait_rsp(cyc);
        chk("sg_latency", cyc, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 1);
            chk("bp_m11", rsp_mat[1][1], -6);
            chk("bp_ready", req_ready, 0);
            @(negedge clk);
        end
        chk_mat("sg", -2, -4, 3, -6);
        do_rsp();

        // Stale done on the first RUN cycle must be ignored.
        tb_lat = 0;
        #1;
        chk("st_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(cyc);
        chk("st_latency", cyc, 4);
        chk_mat("st", 1, 2, 3, 4);
        do_rsp();
        tb_lat = 1;

        // Reset on the second RUN cycle; last was 0, reset restores 1.
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("mr_in_run", mm_enable, 1);
        reset = 1'b1;
        #1;
        chk("mr_enable", mm_enable, 0);
        chk("mr_mm_reset", mm_reset, 1);
        chk("mr_rsp_valid", rsp_valid, 0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("mr_no_rsp", rsp_valid, 0);
        reset = 1'b0;
        #1;
        chk("mr_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(cyc);
        chk("mr_latency", cyc, 4);
        chk("mr_id", rsp_id, 0);
        do_rsp();

        // Datapath never signals done.
        tb_force_low = 1'b1;
        req_valid = 2'b10;
        #1;
        chk("wd_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
`ifdef MAT_SCHED_TIMEOUT_EN
        wait_rsp(cyc);
        chk("wd_latency", cyc, 10);
        chk("wd_err", rsp_error, 1);
        chk_mat("wd", 0, 0, 0, 0);
        chk("wd_id", rsp_id, 1);
        do_rsp();
        tb_force_low = 1'b0;
`else
        repeat (20) @(negedge clk);
        chk("hang_valid", rsp_valid, 0);
        chk("hang_enable", mm_enable, 1);
        tb_force_low = 1'b0;
        wait_rsp(cyc);
        chk("hang_rsp", rsp_valid, 1);
        chk("hang_err", rsp_error, 0);
        chk_mat("hang", -2, -4, 3, -6);
        do_rsp();
`endif

        chk("ready_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_mult_sched.md
# mat_mult_sched

Round-robin scheduler that shares one `mat_mult` datapath between two requesters. Each accepted job goes through four steps: latch the operands, clear the datapath, run it until `mult_done`, then return the result matrix through a valid/ready response port. It sits between the client logic and the single `mat_mult` instance, and it owns that instance's `reset`, `enable_mult`, `mat1` and `mat2` inputs.

## Interface
Parameters:
- `N_ROWS`, default 2: matrix rows, passed unchanged to `mat_mult`.
- `N_COLUMNS`, default 2: matrix columns, passed unchanged to `mat_mult`.
- `TIMEOUT_CYCLES`, default 64: maximum RUN cycles before a job is aborted. Used only with `MAT_SCHED_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; every flop is rising-edge triggered.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  [1:0]  per-requester job request.
- `req_ready`  out  [1:0]  one-hot acceptance pulse.
- `req_mat1`  in  int [0:1][0:N_ROWS-1][0:N_COLUMNS-1]  left operand, one per requester.
- `req_mat2`  in  int [0:1][0:N_ROWS-1][0:N_COLUMNS-1]  right operand, one per requester.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  1  index of the requester that owns the result.
- `rsp_error`  out  1  job aborted on timeout.
- `rsp_mat`  out  int [0:N_ROWS-1][0:N_COLUMNS-1]  result matrix.
- `mm_reset`  out  1  drives `mat_mult` `reset`.
- `mm_enable`  out  1  drives `mat_mult` `enable_mult`.
- `mm_mat1`  out  int [0:N_ROWS-1][0:N_COLUMNS-1]  drives `mat_mult` `mat1`.
- `mm_mat2`  out  int [0:N_ROWS-1][0:N_COLUMNS-1]  drives `mat_mult` `mat2`.
- `mm_done`  in  1  from `mat_mult` `mult_done`.
- `mm_mat_out`  in  int [0:N_ROWS-1][0:N_COLUMNS-1]  from `mat_mult` `mat_out`.

## Operation
States are IDLE, CLEAR, RUN and RESP.
- **IDLE**
  - Arbitration is round-robin using pointer `last`; reset value is 1, so requester 0 wins first.
  - If only one `req_valid` bit is set, that requester wins.
  - If both are set, the winner is requester `~last`.
  - `req_ready[winner]` is 1 for this one cycle only.
  - At the edge the scheduler latches `req_mat1[winner]`, `req_mat2[winner]` and the winner id, sets `last` to the winner and goes to CLEAR.
  - If no request is pending it stays in IDLE.
- **CLEAR**
  - Lasts exactly one cycle with `mm_reset`=1 and `mm_enable`=0, then goes to RUN.
- **RUN**
  - `mm_enable`=1. `mm_mat1` and `mm_mat2` come from the latched registers at all times, including outside RUN.
  - Run counter `run_cnt` is 0 on the first RUN cycle.
  - `mm_done` is ignored while `run_cnt`=0, because the datapath's done flag is stale at that point.
  - On the first edge with `run_cnt`≥1 and `mm_done`=1:
    - `mm_mat_out` is captured into `rsp_mat`;
    - `rsp_error` is set to 0;
    - the state goes to RESP.
- **RESP**
  - `rsp_valid`=1, and `rsp_mat`, `rsp_id` and `rsp_error` are held stable.
  - On an edge with `rsp_ready`=1 the state goes to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- **Outputs**
  - `mm_reset` = `reset` OR (state==CLEAR).
  - `req_ready` is 0 in every state except IDLE.
- **Arithmetic**
  - `int` is 32-bit signed, and products and sums wrap mod 2^32. The scheduler itself performs no arithmetic.

## Timing
- **Reset values** (asynchronous):
  - state = IDLE, `last` = 1;
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_error` = 0;
  - `rsp_mat` = all 0;
  - `mm_enable` = 0, `mm_reset` = 1 while `reset` is high;
  - latched operands = all 0.
- **Reset mid-operation**: from any state the block returns to IDLE immediately. Any pending response is lost and no `rsp_valid` is produced for it.
- **Latency**:
  - Cycle after the `req_ready` pulse: CLEAR.
  - Next cycle: first RUN cycle.
  - `rsp_valid` rises the cycle after `mm_done` is sampled.
  - Minimum latency from the `req_ready` cycle to the first `rsp_valid` cycle is 4 cycles.
- **Request rules**:
  - A requester holds `req_valid` and its operands stable until it sees `req_ready`.
  - Operands are sampled only on the acceptance edge; changing them afterwards does not affect the job.
- **Back-to-back jobs**: minimum spacing between accepted jobs is 5 cycles (IDLE, CLEAR, 2×RUN, RESP).

## Configuration
Macro: `MAT_SCHED_TIMEOUT_EN`.
- **Defined**:
  - A RUN watchdog is compiled in.
  - If `run_cnt` reaches `TIMEOUT_CYCLES`-1 without a qualifying `mm_done`, the scheduler goes to RESP with `rsp_error`=1 and `rsp_mat`=all 0.
  - `run_cnt` saturates at the timeout value and is never wider than $clog2(`TIMEOUT_CYCLES`)+1 bits.
- **Undefined**:
  - No watchdog logic is compiled.
  - RUN waits indefinitely for `mm_done`.
  - `rsp_error` is tied to 0.

## Test plan
- **Identity multiply**: requester 0 sends mat1 = identity, mat2 = [[1,2],[3,4]] → `rsp_mat` = [[1,2],[3,4]], `rsp_id`=0, `rsp_error`=0, first `rsp_valid` at least 4 cycles after `req_ready[0]`.
- **Signed operands**: requester 1 sends [[-1,2],[0,3]]×[[4,0],[1,-2]] → `rsp_mat` = [[-2,-4],[3,-6]], `rsp_id`=1.
- **Simultaneous requests**: both `req_valid` high from reset → grant order 0,1,0,1 over four jobs. `req_ready` is never two-hot and never asserted outside IDLE.
- **Back-pressure**: hold `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_mat` and `rsp_id` stay stable, and no `req_ready` pulse while requests are pending.
- **Reset mid-RUN**: assert `reset` on the second RUN cycle → `mm_enable`=0, `mm_reset`=1 and `rsp_valid`=0 immediately. After release, requester 0 is granted first.
- **Watchdog** (`MAT_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): force `mm_done`=0 → RESP after 8 RUN cycles with `rsp_error`=1 and `rsp_mat`=0.
